// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline hazard controller.
//   hazard_state_t : controller FSM encoding (RUN, MEM_WAIT, FAULT)
//   RES_MEM        : Execute result-mux select value that marks a load
//   REG_ZERO       : scalar x0 index (never a real dependency)
//   is_load_use()  : load-use hazard detector shared by RTL users
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FAULT    = 2'b10
    } hazard_state_t;

    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [5:0] REG_ZERO = 6'd0;

    // A load in Execute whose destination feeds either Decode source.
    // Only index 0 is excluded: 6'd32 is a real vector register.
    function automatic logic is_load_use(
        input logic [1:0] result_source,
        input logic       write_scalar,
        input logic       write_vector,
        input logic [5:0] rd,
        input logic [5:0] r1,
        input logic [5:0] r2
    );
        logic is_load;
        logic writes;
        logic match;
        is_load = (result_source == RES_MEM);
        writes  = write_scalar | write_vector;
        match   = (rd == r1) | (rd == r2);
        return is_load & writes & (rd != REG_ZERO) & match;
    endfunction

endpackage

// File: rtl/sat_event_counter.sv
// -----------------------------------------------------------------------------
// sat_event_counter
// Saturating event counter with synchronous clear (clear wins over increment).
// Ports:
//   clock       in   clock
//   async_reset in   asynchronous active-low reset
//   inc         in   count one event this cycle
//   clr         in   synchronous clear
//   count       out  W-bit count, sticks at all-ones
// -----------------------------------------------------------------------------
module sat_event_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         async_reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear first, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipe_hazard_controller
// Central stall/flush controller for the five-stage scalar+vector pipeline.
// Drives active-high hold enables and active-low flushes of the pipeline
// registers from load-use hazards, Execute redirects and memory wait states.
// Stall/flush outputs are combinational (same-cycle effect on the registers).
//
// Optional feature macro: HAZARD_PERF_COUNTERS_EN
//   defined     : stall/flush/load-use saturating performance counters built
//   not defined : counter ports tied to zero, no counter flops
//
// Ports:
//   clock, async_reset                 clock, async active-low reset
//   r1_D, r2_D                         Decode source indices (bit 5 = vector)
//   rd_E, result_source_E              Execute destination and result select
//   write_scalar_reg_E/write_vector_reg_E  Execute write-back enables
//   redirect_E                         taken branch/jump resolved in Execute
//   memory_transaction_M, mem_ready    Memory stage handshake
//   counter_clear                      synchronous perf-counter clear
//   enable_F..enable_W                 stage register enables
//   flush_D_n, flush_E_n               active-low D/E register flushes
//   mem_fault                          sticky memory-timeout flag
//   stall_cycles, flush_events, load_use_events   perf counters
// -----------------------------------------------------------------------------
module pipe_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 1024,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             async_reset,
    input  logic [5:0]       r1_D,
    input  logic [5:0]       r2_D,
    input  logic [5:0]       rd_E,
    input  logic [1:0]       result_source_E,
    input  logic             write_scalar_reg_E,
    input  logic             write_vector_reg_E,
    input  logic             redirect_E,
    input  logic             memory_transaction_M,
    input  logic             mem_ready,
    input  logic             counter_clear,
    output logic             enable_F,
    output logic             enable_D,
    output logic             enable_E,
    output logic             enable_M,
    output logic             enable_W,
    output logic             flush_D_n,
    output logic             flush_E_n,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] load_use_events
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    hazard_state_t     state_q;
    hazard_state_t     state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;

    logic       load_use_s;
    logic       mem_stall_s;
    logic [4:0] enables_s;      // {F, D, E, M, W}
    logic       flush_d_n_s;
    logic       flush_e_n_s;
    logic       bubble_s;       // load-use bubble actually inserted

    assign load_use_s  = is_load_use(result_source_E, write_scalar_reg_E,
                                     write_vector_reg_E, rd_E, r1_D, r2_D);
    assign mem_stall_s = memory_transaction_M & ~mem_ready;

    // Priority resolution: freeze > redirect flush > load-use bubble > run.
    always_comb begin
        enables_s   = 5'b11111;
        flush_d_n_s = 1'b1;
        flush_e_n_s = 1'b1;
        bubble_s    = 1'b0;
        if ((state_q == FAULT) || mem_stall_s) begin
            // Frozen pipeline: redirect and load-use wait until it moves again.
            enables_s = 5'b00000;
        end else if (redirect_E) begin
            // The load-use consumer sits in Decode and is flushed anyway.
            flush_d_n_s = 1'b0;
            flush_e_n_s = 1'b0;
        end else if (load_use_s) begin
            enables_s   = 5'b00111;
            flush_e_n_s = 1'b0;
            bubble_s    = 1'b1;
        end else begin
            enables_s   = 5'b11111;
        end
    end

    assign enable_F  = enables_s[4];
    assign enable_D  = enables_s[3];
    assign enable_E  = enables_s[2];
    assign enable_M  = enables_s[1];
    assign enable_W  = enables_s[0];
    assign flush_D_n = flush_d_n_s;
    assign flush_E_n = flush_e_n_s;
    assign mem_fault = (state_q == FAULT);

    // FSM next state and memory-wait counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (mem_stall_s) begin
                    state_d = MEM_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall_s) begin
                    state_d    = RUN;
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Hold the count so it never wraps on the way to FAULT.
                    state_d    = FAULT;
                    wait_cnt_d = wait_cnt_q;
                end else begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            FAULT: begin
                state_d    = FAULT;
                wait_cnt_d = wait_cnt_q;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // FSM and wait-counter registers.
    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic stall_any_s;
    logic flush_any_s;

    assign stall_any_s = ~(&enables_s);
    assign flush_any_s = ~flush_d_n_s | ~flush_e_n_s;

    sat_event_counter #(.W(CNT_W)) u_stall_cnt (
        .clock       (clock),
        .async_reset (async_reset),
        .inc         (stall_any_s),
        .clr         (counter_clear),
        .count       (stall_cycles)
    );

    sat_event_counter #(.W(CNT_W)) u_flush_cnt (
        .clock       (clock),
        .async_reset (async_reset),
        .inc         (flush_any_s),
        .clr         (counter_clear),
        .count       (flush_events)
    );

    sat_event_counter #(.W(CNT_W)) u_load_use_cnt (
        .clock       (clock),
        .async_reset (async_reset),
        .inc         (bubble_s),
        .clr         (counter_clear),
        .count       (load_use_events)
    );
`else
    logic unused_perf_s;
    assign unused_perf_s   = counter_clear | bubble_s;
    assign stall_cycles    = '0;
    assign flush_events    = '0;
    assign load_use_events = '0;
`endif

endmodule
